ace_responder: RTL and testbench



---
 rtl/ace_pkg.sv | 31 +++
 rtl/ace_backing_mem.sv | 30 +++
 rtl/ace_responder.sv | 170 +++++++++++++++++
 tb/tb_ace_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// Shared types for the ACE responder: coherent line states, latched opcodes and FSM states.
package ace_pkg;

    typedef enum logic [2:0] {
        INVALID   = 3'b000,
        MODIFIED  = 3'b001,
        SHARED    = 3'b010,
        OWNED     = 3'b011,
        EXCLUSIVE = 3'b100
    } line_state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INV   = 2'd2
    } ace_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_fsm_t;

    // Winner among simultaneously raised requests: write-back beats invalidate beats read.
    function automatic ace_op_t pick_op(input logic wr, input logic inv);
        if (wr)       return OP_WRITE;
        else if (inv) return OP_INV;
        else          return OP_READ;
    endfunction

endpackage

// File: rtl/ace_backing_mem.sv
// Backing store for the responder: synchronous write, combinational read,
// every word cleared while reset is low.
module ace_backing_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ace_responder.sv
// Interconnect-side ACE responder: accepts one request at a time, waits a fixed
// memory latency, then returns fill data and the granted line state with a one-cycle ace_ready.
//
// state | meaning
// IDLE  | waiting for any request; accept latches opcode, index, wdata, snoop_shared
// WAIT  | counting down the memory latency
// RESP  | memory updated on entry; response registered onto the outputs at exit
module ace_responder
    import ace_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req,
    input  logic              write_req,
    input  logic              invalid_req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              snoop_shared,
    output logic              ace_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [2:0]        resp_state,
    output logic              busy,
    output logic              req_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

    resp_fsm_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ace_op_t           op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              shared_q, shared_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    line_state_t       rstate_q, rstate_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              any_req;
    logic              multi_req;
    ace_op_t           acc_op;
    logic              unused_addr_bits;

    assign any_req          = read_req | write_req | invalid_req;
    assign multi_req        = (read_req & write_req) | (read_req & invalid_req) | (write_req & invalid_req);
    assign acc_op           = pick_op(write_req, invalid_req);
    assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W];

    ace_backing_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        shared_d  = shared_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        rstate_d  = rstate_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_d      = acc_op;
                    idx_d     = req_addr[IDX_W-1:0];
                    wdata_d   = req_wdata;
                    shared_d  = snoop_shared;
                    err_d     = multi_req;
                    // Zero latency enters RESP straight from accept, so the write uses live inputs.
                    mem_idx   = req_addr[IDX_W-1:0];
                    mem_wdata = req_wdata;
                    if (MEM_LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                        mem_we  = (acc_op == OP_WRITE);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    mem_we  = (op_q == OP_WRITE);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                case (op_q)
                    OP_WRITE: begin
                        rdata_d  = wdata_q;
                        rstate_d = INVALID;
                    end
                    OP_INV: begin
                        rdata_d  = mem_rdata;
                        rstate_d = MODIFIED;
                    end
                    default: begin
                        rdata_d  = mem_rdata;
                        rstate_d = shared_q ? SHARED : EXCLUSIVE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_READ;
            idx_q    <= '0;
            wdata_q  <= '0;
            shared_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            rstate_q <= INVALID;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            shared_q <= shared_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rstate_q <= rstate_d;
            err_q    <= err_d;
        end
    end

    assign ace_ready  = ready_q;
    assign resp_rdata = rdata_q;
    assign resp_state = rstate_q;
    assign busy       = (state_q != IDLE);
    assign req_err    = err_q;

endmodule

// File: tb/tb_ace_responder.sv
// Directed bench for ace_responder: default-latency instance plus a zero-latency instance.
module tb_ace_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        read_req, write_req, invalid_req, snoop_shared;
    logic [31:0] req_addr, req_wdata;
    logic        ace_ready, busy, req_err;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_state;

    logic        read_req_z, write_req_z, invalid_req_z, snoop_shared_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic        ace_ready_z, busy_z, req_err_z;
    logic [31:0] resp_rdata_z;
    logic [2:0]  resp_state_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ace_responder dut (
        .clk          (clk),
        .reset        (reset),
        .read_req     (read_req),
        .write_req    (write_req),
        .invalid_req  (invalid_req),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .snoop_shared (snoop_shared),
        .ace_ready    (ace_ready),
        .resp_rdata   (resp_rdata),
        .resp_state   (resp_state),
        .busy         (busy),
        .req_err      (req_err)
    );

    ace_responder #(.MEM_LATENCY(0)) dut_z (
        .clk          (clk),
        .reset        (reset),
        .read_req     (read_req_z),
        .write_req    (write_req_z),
        .invalid_req  (invalid_req_z),
        .req_addr     (req_addr_z),
        .req_wdata    (req_wdata_z),
        .snoop_shared (snoop_shared_z),
        .ace_ready    (ace_ready_z),
        .resp_rdata   (resp_rdata_z),
        .resp_state   (resp_state_z),
        .busy         (busy_z),
        .req_err      (req_err_z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit z, input bit rd, input bit wr, input bit iv,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit sh);
        if (z) begin
            read_req_z = rd; write_req_z = wr; invalid_req_z = iv;
            req_addr_z = addr; req_wdata_z = wdata; snoop_shared_z = sh;
        end else begin
            read_req = rd; write_req = wr; invalid_req = iv;
            req_addr = addr; req_wdata = wdata; snoop_shared = sh;
        end
    endtask

    // One transaction: lat = edges after the accept edge until ace_ready is seen (99 = never).
    task automatic txn(input bit z, input bit rd, input bit wr, input bit iv,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit sh,
                       input bit hold,
                       output int lat, output int bsy, output logic [31:0] rdata,
                       output logic [2:0] st, output logic err, output logic err2,
                       output int extra);
        logic rdy;
        lat = 99; bsy = 0; extra = 0; err2 = 1'b0;
        rdata = 'x; st = 'x;
        set_req(z, rd, wr, iv, addr, wdata, sh);
        step();
        err = z ? req_err_z : req_err;
        if (z ? busy_z : busy) bsy++;
        if (!hold) set_req(z, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            rdy = z ? ace_ready_z : ace_ready;
            if (k == 1) err2 = z ? req_err_z : req_err;
            if (rdy) begin
                lat   = k;
                rdata = z ? resp_rdata_z : resp_rdata;
                st    = z ? resp_state_z : resp_state;
                set_req(z, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
                break;
            end
            if (z ? busy_z : busy) bsy++;
        end
        for (int k = 0; k < 2; k++) begin
            step();
            if (z ? ace_ready_z : ace_ready) extra++;
        end
    endtask

    int          lat, bsy, extra;
    logic [31:0] rd;
    logic [2:0]  st;
    logic        err, err2;

    initial begin
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        chk("rst_ready", 32'(ace_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(req_err), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_state", 32'(resp_state), 32'h0);
        chk("rst_z_ready", 32'(ace_ready_z), 32'h0);
        chk("rst_z_state", 32'(resp_state_z), 32'h0);
        reset = 1'b1;
        step();

        // Read of a cleared word, exclusive grant
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("rd4_lat", 32'(lat), 32'd5);
        chk("rd4_busy_cycles", 32'(bsy), 32'd5);
        chk("rd4_rdata", rd, 32'h0);
        chk("rd4_state", 32'(st), 32'h4);
        chk("rd4_err", 32'(err), 32'h0);
        chk("rd4_single_ready", 32'(extra), 32'h0);
        chk("rd4_idle_after", 32'(busy), 32'h0);

        txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h3, 32'hDEADBEEF, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("wr3_lat", 32'(lat), 32'd5);
        chk("wr3_rdata", rd, 32'hDEADBEEF);
        chk("wr3_state", 32'(st), 32'h0);

        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("rd13_alias_rdata", rd, 32'hDEADBEEF);
        chk("rd13_state", 32'(st), 32'h2);

        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("inv3_rdata", rd, 32'hDEADBEEF);
        chk("inv3_state", 32'(st), 32'h1);

        // Read and write together: write wins, one error pulse, one completion
        txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h12345678, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("multi_err", 32'(err), 32'h1);
        chk("multi_err_pulse", 32'(err2), 32'h0);
        chk("multi_lat", 32'(lat), 32'd5);
        chk("multi_rdata", rd, 32'h12345678);
        chk("multi_state", 32'(st), 32'h0);
        chk("multi_single_ready", 32'(extra), 32'h0);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("rd5_rdata", rd, 32'h12345678);
        chk("rd5_state", 32'(st), 32'h4);

        // Reset during WAIT of a write aborts it
        set_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h7, 32'hA5A5A5A5, 1'b0);
        step();
        step();
        chk("abort_busy_wait", 32'(busy), 32'h1);
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(ace_ready), 32'h0);
        reset = 1'b1;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ace_ready) extra++;
        end
        chk("abort_no_ready", 32'(extra), 32'h0);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("abort_rd7_rdata", rd, 32'h0);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h3, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("rst_cleared_rd3", rd, 32'h0);

        // Request dropped right after accept still completes
        txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0BADF00D, 1'b0, 1'b0, lat, bsy, rd, st, err, err2, extra);
        chk("drop_lat", 32'(lat), 32'd5);
        chk("drop_rdata", rd, 32'h0BADF00D);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h9, 32'h0, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("drop_rd9_rdata", rd, 32'h0BADF00D);

        // Zero-latency instance
        txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h2, 32'hCAFEF00D, 1'b0, 1'b1, lat, bsy, rd, st, err, err2, extra);
        chk("z_wr_lat", 32'(lat), 32'd1);
        chk("z_wr_busy_cycles", 32'(bsy), 32'd1);
        chk("z_wr_state", 32'(st), 32'h0);
        txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, lat, bsy, rd, st, err, err2, extra);
        chk("z_drop_lat", 32'(lat), 32'd1);
        chk("z_rd_rdata", rd, 32'hCAFEF00D);
        chk("z_rd_state", 32'(st), 32'h2);

        // Request held through ace_ready is accepted again two cycles after the first accept
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0, 1'b0);
        step();
        chk("z_b2b_busy0", 32'(busy_z), 32'h1);
        step();
        chk("z_b2b_ready1", 32'(ace_ready_z), 32'h1);
        chk("z_b2b_state1", 32'(resp_state_z), 32'h4);
        step();
        chk("z_b2b_reaccept_busy", 32'(busy_z), 32'h1);
        chk("z_b2b_gap", 32'(ace_ready_z), 32'h0);
        step();
        chk("z_b2b_ready2", 32'(ace_ready_z), 32'h1);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("z_b2b_end_ready", 32'(ace_ready_z), 32'h0);
        chk("z_b2b_end_busy", 32'(busy_z), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
